ball_job_seq: RTL and testbench
===============================

Name: ball_job_seq

Overview:
Job sequencer directly upstream of the ball2001-style location-machine program block.
- Accepts operand jobs (x, y, w) over a valid/ready handshake.
- Launches the program with a one-cycle start pulse and watches its one-hot location vector until a terminal location or a timeout.
- Returns a result code and cycle count over a second valid/ready handshake.

Parameters:
W, 3, operand width of x/y/w.
CW, 5, width of the run-cycle counter and out_cycles.
TMO_CYCLES, 31, RUN-cycle limit before timeout; legal range 1 .. 2^CW-1.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  job offered.
in_ready  output  1  job accepted when in_valid && in_ready.
in_x  input  W  operand X.
in_y  input  W  operand Y.
in_w  input  W  operand W.
prog_start  output  1  one-cycle launch pulse to the program block.
prog_x  output  W  captured X; stable from LAUNCH through REPORT.
prog_y  output  W  captured Y; same stability rule as prog_x.
prog_w  output  W  captured W; same stability rule as prog_x.
prog_loc  input  9  program location vector L8..L0 (bit i = Li).
out_valid  output  1  result available.
out_ready  input  1  result consumed when out_valid && out_ready.
out_code  output  2  00 = L8 reached (pass), 01 = L7 reached (fail), 10 = timeout, 11 = location not one-hot.
out_cycles  output  CW  number of RUN cycles, including the deciding cycle.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: state = IDLE. Every register-driven output (prog_start, prog_x, prog_y, prog_w, out_valid, out_code, out_cycles, busy) resets to 0. in_ready is a decode of the state, so it is 1 during and after reset.
- The FSM has four states: IDLE, LAUNCH, RUN, REPORT. The state register is one-hot.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture in_x/in_y/in_w into prog_x/prog_y/prog_w and go to LAUNCH next cycle.
- LAUNCH:
  - prog_start = 1 for exactly this cycle.
  - Cycle counter cleared to 0.
  - Go to RUN next cycle.
- RUN:
  - Counter increments every cycle and saturates at 2^CW-1.
  - Checks are made each cycle on the current prog_loc, in priority order:
    1. prog_loc not exactly one-hot (zero bits set, or two or more bits set, including L7 and L8 together) -> code 11.
    2. prog_loc[8] -> code 00.
    3. prog_loc[7] -> code 01.
    4. counter+1 == TMO_CYCLES with no terminal location -> code 10.
  - On any decision: latch out_code and out_cycles = counter+1, then go to REPORT next cycle.
- REPORT:
  - out_valid = 1; out_code and out_cycles held stable.
  - On out_ready: go to IDLE next cycle; out_valid drops that same next cycle.
- in_ready = 0 in LAUNCH, RUN and REPORT. in_valid offered in those states is ignored and not queued.
- Back-to-back jobs: the earliest acceptance of the next job is the IDLE cycle after REPORT handshake completes. Minimum job turnaround is 4 cycles.
- prog_loc is ignored outside RUN.
- Reset asserted mid-job (any state): next cycle is IDLE with all outputs cleared. A partial result is never emitted.
- out_cycles for a decision on the first RUN cycle = 1. A timeout always reports out_cycles = TMO_CYCLES.

Optional Feature:
BALL_SEQ_ASSERT_EN
- Defined: adds concurrent assertions.
  - The state register is always one-hot.
  - prog_start is never high in two consecutive cycles.
  - out_valid && out_code == 2'b01 never occurs (the program's L7 is unreachable), plus a prop/prop_neg wire pair for the checker.
- Undefined: no assertion logic. Ports and cycle behaviour are identical.

Test Plan:
- Job x=2, y=2, w=1; stub holds prog_loc = 9'h001 for 3 RUN cycles, then 9'h100; out_ready = 1 -> prog_start pulses once; out_code = 00, out_cycles = 4.
- Stub drives 9'h080 on the 2nd RUN cycle -> out_code = 01, out_cycles = 2; with BALL_SEQ_ASSERT_EN, the assertion fires.
- Stub holds 9'h004 forever, TMO_CYCLES = 31 -> out_code = 10, out_cycles = 31.
- Stub drives 9'h000 on the 1st RUN cycle -> code 11, cycles 1. Stub drives 9'h180 -> code 11, not 00.
- out_ready held 0 for 5 cycles in REPORT while in_valid = 1 with new operands -> out_valid, code and cycles stable; in_ready = 0; the new job is accepted only in the IDLE cycle after the handshake.
- rst pulsed on the 2nd RUN cycle -> next cycle: IDLE, in_ready = 1, out_valid = 0, prog_x/y/w = 0; the following job completes normally.

Source files
------------

// File: rtl/ball_job_seq_if.sv
// Job, program and result signals of the ball job sequencer.
// master = job source / program side, slave = sequencer.
interface ball_job_seq_if #(
    parameter int W  = 3,
    parameter int CW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [W-1:0]  in_y;
    logic [W-1:0]  in_w;
    logic          prog_start;
    logic [W-1:0]  prog_x;
    logic [W-1:0]  prog_y;
    logic [W-1:0]  prog_w;
    logic [8:0]    prog_loc;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_code;
    logic [CW-1:0] out_cycles;
    logic          busy;

    modport master (
        output in_valid, in_x, in_y, in_w, prog_loc, out_ready,
        input  in_ready, prog_start, prog_x, prog_y, prog_w,
        input  out_valid, out_code, out_cycles, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_w, prog_loc, out_ready,
        output in_ready, prog_start, prog_x, prog_y, prog_w,
        output out_valid, out_code, out_cycles, busy
    );
endinterface

// File: rtl/ball_job_seq.sv
// Job sequencer feeding the location-machine program block.
// Optional BALL_SEQ_ASSERT_EN adds concurrent protocol assertions.
module ball_job_seq #(
    parameter int W          = 3,
    parameter int CW         = 5,
    parameter int TMO_CYCLES = 31
) (
    input logic           clk,
    input logic           rst,
    ball_job_seq_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        LAUNCH = 4'b0010,
        RUN    = 4'b0100,
        REPORT = 4'b1000
    } state_t;

    state_t        state;
    logic          start;
    logic [W-1:0]  op_x;
    logic [W-1:0]  op_y;
    logic [W-1:0]  op_w;
    logic          valid;
    logic [1:0]    code;
    logic [CW-1:0] cycles;
    logic          busy;
    logic [CW-1:0] cnt;

    logic [CW-1:0] cnt_nxt;
    logic          one_hot;
    logic          decide;
    logic [1:0]    code_nxt;

    // Saturating count of RUN cycles including the current one.
    assign cnt_nxt = (cnt == '1) ? cnt : cnt + CW'(1);

    always_comb begin
        one_hot  = (bus.prog_loc != '0) &&
                   ((bus.prog_loc & (bus.prog_loc - 9'd1)) == '0);
        decide   = 1'b1;
        code_nxt = 2'b00;
        if (!one_hot) begin
            code_nxt = 2'b11;
        end else if (bus.prog_loc[8]) begin
            code_nxt = 2'b00;
        end else if (bus.prog_loc[7]) begin
            code_nxt = 2'b01;
        end else if (cnt_nxt == CW'(TMO_CYCLES)) begin
            code_nxt = 2'b10;
        end else begin
            decide = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            start  <= 1'b0;
            op_x   <= '0;
            op_y   <= '0;
            op_w   <= '0;
            valid  <= 1'b0;
            code   <= '0;
            cycles <= '0;
            busy   <= 1'b0;
            cnt    <= '0;
        end else begin
            start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_x  <= bus.in_x;
                        op_y  <= bus.in_y;
                        op_w  <= bus.in_w;
                        start <= 1'b1;
                        busy  <= 1'b1;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt_nxt;
                    if (decide) begin
                        code   <= code_nxt;
                        cycles <= cnt_nxt;
                        valid  <= 1'b1;
                        state  <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.out_ready) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.prog_start = start;
    assign bus.prog_x     = op_x;
    assign bus.prog_y     = op_y;
    assign bus.prog_w     = op_w;
    assign bus.out_valid  = valid;
    assign bus.out_code   = code;
    assign bus.out_cycles = cycles;
    assign bus.busy       = busy;

`ifdef BALL_SEQ_ASSERT_EN
    // L7 is unreachable in the program, so a fail code is a bug.
    wire l7_prop     = valid && (code == 2'b01);
    wire l7_prop_neg = !l7_prop;

    a_state_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot(state));
    a_start_pulse: assert property (
        @(posedge clk) disable iff (rst) start |=> !start);
    a_no_l7: assert property (
        @(posedge clk) disable iff (rst) l7_prop_neg);
`endif
endmodule

// File: tb/tb_ball_job_seq.sv
// Directed bench for ball_job_seq with a table-driven program stub.
module tb_ball_job_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ball_job_seq_if #(.W(3), .CW(5)) bus ();

    ball_job_seq #(.W(3), .CW(5), .TMO_CYCLES(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int run_idx = 63;
    logic [8:0] loc_tab [64];

    // Stub program: location indexed by RUN cycle since launch.
    always @(posedge clk) begin
        if (bus.prog_start) begin
            run_idx <= 0;
            n_start <= n_start + 1;
        end else if (run_idx < 63) begin
            run_idx <= run_idx + 1;
        end
    end

    assign bus.prog_loc = loc_tab[run_idx];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tab(input logic [8:0] first, input int n,
                           input logic [8:0] rest);
        for (int i = 0; i < 64; i++)
            loc_tab[i] = (i < n) ? first : rest;
    endtask

    task automatic start_job(input logic [2:0] x, input logic [2:0] y,
                             input logic [2:0] w);
        bus.in_valid = 1'b1;
        bus.in_x = x;
        bus.in_y = y;
        bus.in_w = w;
        check("idle_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("launch_start", 32'(bus.prog_start), 32'd1);
        check("launch_ready", 32'(bus.in_ready), 32'd0);
        check("launch_busy", 32'(bus.busy), 32'd1);
        check("prog_x", 32'(bus.prog_x), 32'(x));
        check("prog_y", 32'(bus.prog_y), 32'(y));
        check("prog_w", 32'(bus.prog_w), 32'(w));
    endtask

    task automatic wait_result(input string tag, input logic [1:0] code,
                               input logic [4:0] cyc);
        logic seen;
        for (int i = 0; i < 50 && !bus.out_valid; i++)
            tick();
        seen = bus.out_valid;
        check({tag, "_valid"}, 32'(seen), 32'd1);
        check({tag, "_code"}, 32'(bus.out_code), 32'(code));
        check({tag, "_cycles"}, 32'(bus.out_cycles), 32'(cyc));
    endtask

    task automatic finish_job(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic job(input string tag, input logic [2:0] x,
                       input logic [1:0] code, input logic [4:0] cyc);
        int s0;
        s0 = n_start;
        start_job(x, 3'd1, 3'd6);
        wait_result(tag, code, cyc);
        check({tag, "_starts"}, 32'(n_start - s0), 32'd1);
        finish_job(tag);
    endtask

    initial begin
        int s0;
        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.in_w = '0;
        bus.out_ready = 1'b0;
        set_tab(9'h001, 64, 9'h001);

        tick();
        tick();
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_start", 32'(bus.prog_start), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_px", 32'(bus.prog_x), 32'd0);
        check("rst_code", 32'(bus.out_code), 32'd0);
        check("rst_cyc", 32'(bus.out_cycles), 32'd0);
        rst = 1'b0;
        tick();

        // Pass after three L0 cycles.
        set_tab(9'h001, 3, 9'h100);
        s0 = n_start;
        start_job(3'd2, 3'd2, 3'd1);
        wait_result("pass", 2'b00, 5'd4);
        check("pass_px", 32'(bus.prog_x), 32'd2);
        check("pass_starts", 32'(n_start - s0), 32'd1);
        finish_job("pass");

        set_tab(9'h001, 1, 9'h080);
        job("l7", 3'd3, 2'b01, 5'd2);

        set_tab(9'h004, 64, 9'h004);
        job("tmo", 3'd4, 2'b10, 5'd31);

        set_tab(9'h000, 64, 9'h000);
        job("zero", 3'd5, 2'b11, 5'd1);

        set_tab(9'h180, 64, 9'h180);
        job("l78", 3'd6, 2'b11, 5'd1);

        set_tab(9'h001, 2, 9'h003);
        job("two", 3'd7, 2'b11, 5'd3);

        // Stall in REPORT with a new job pending.
        set_tab(9'h001, 2, 9'h100);
        start_job(3'd2, 3'd3, 3'd4);
        wait_result("stall", 2'b00, 5'd3);
        bus.in_valid = 1'b1;
        bus.in_x = 3'd5;
        bus.in_y = 3'd6;
        bus.in_w = 3'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_code", 32'(bus.out_code), 32'd0);
            check("stall_cyc", 32'(bus.out_cycles), 32'd3);
            check("stall_ready", 32'(bus.in_ready), 32'd0);
            check("stall_px", 32'(bus.prog_x), 32'd2);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hs_valid", 32'(bus.out_valid), 32'd0);
        check("hs_ready", 32'(bus.in_ready), 32'd1);
        check("hs_start", 32'(bus.prog_start), 32'd0);
        check("hs_px", 32'(bus.prog_x), 32'd2);
        set_tab(9'h100, 64, 9'h100);
        start_job(3'd5, 3'd6, 3'd7);
        wait_result("next", 2'b00, 5'd1);
        finish_job("next");

        // Reset on the second RUN cycle.
        set_tab(9'h001, 64, 9'h001);
        start_job(3'd1, 3'd2, 3'd3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_ready", 32'(bus.in_ready), 32'd1);
        check("mid_valid", 32'(bus.out_valid), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_px", 32'(bus.prog_x), 32'd0);
        check("mid_py", 32'(bus.prog_y), 32'd0);
        check("mid_pw", 32'(bus.prog_w), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_quiet", 32'(bus.out_valid), 32'd0);
        end
        set_tab(9'h001, 1, 9'h100);
        job("after", 3'd3, 2'b00, 5'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
